ddr_cmd_sequencer: RTL

Command-issuing engine on the far side of the controller handshake (rw_proc / rw_idle / refresh_rdy / mrs_update_rdy). It accepts read/write transactions while the controller grants rw_proc, expands each into closed-page ACT → RD/WR → PRE command sequences with enforced spacing, and reports rw_idle back. It also executes the refresh (PREA + REF) and mode-register update (MRS) sequences the controller requests. Its command outputs feed the DDR interface driver.

---
 rtl/ddr_cmd_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ddr_cmd_sequencer.sv
// ddr_cmd_sequencer
//   Takes read/write transactions from the controller handshake. Each one is
//   expanded into a closed-page ACT -> RD/WR -> PRE command sequence, with the
//   required spacing between commands. It also runs the refresh sequence
//   (PREA + REF) and the mode-register update sequence (MRS) on request.
//   All outputs are registered.
// Ports
//   clock_t, reset        : rising-edge clock, synchronous active-high reset
//   rw_proc               : controller allows read/write traffic
//   refresh_rdy           : pulse, perform refresh (remembered until it starts)
//   mrs_update_rdy/_cmd   : pulse plus MR0 word, perform MRS
//   req_valid/req_ready   : transaction handshake; req_write/bank/row/col payload
//   rw_idle               : nothing in progress and nothing pending
//   cmd_valid/cmd/cmd_bank/cmd_addr : one-cycle command strobe to the DDR driver
module ddr_cmd_sequencer #(
  parameter int unsigned T_RCD     = 4,
  parameter int unsigned T_BURST   = 4,
  parameter int unsigned T_RP      = 4,
  parameter int unsigned T_RFC     = 20,
  parameter int unsigned T_MOD     = 8,
  parameter int unsigned MRS_WIDTH = 18
) (
  input  logic                 clock_t,
  input  logic                 reset,
  input  logic                 rw_proc,
  input  logic                 refresh_rdy,
  input  logic                 mrs_update_rdy,
  input  logic [MRS_WIDTH-1:0] mrs_update_cmd,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [3:0]           req_bank,
  input  logic [15:0]          req_row,
  input  logic [9:0]           req_col,
  output logic                 rw_idle,
  output logic                 cmd_valid,
  output logic [2:0]           cmd,
  output logic [3:0]           cmd_bank,
  output logic [17:0]          cmd_addr
);

  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_TRCD, S_RW, S_BURST, S_PRE, S_TRP,
    S_PREA, S_PREA_WAIT, S_REF, S_RFC, S_MRS, S_MOD
  } state_e;

  typedef struct packed {
    logic        write;
    logic [3:0]  bank;
    logic [15:0] row;
    logic [9:0]  col;
  } req_t;

  localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3,
                         C_PRE = 3'd4, C_PREA = 3'd5, C_REF = 3'd6, C_MRS = 3'd7;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  req_t                 req_q, req_d;
  logic [MRS_WIDTH-1:0] mrs_word_q, mrs_word_d;
  logic                 ref_pend_q, ref_pend_d, mrs_pend_q, mrs_pend_d;
  logic                 cmd_valid_q, cmd_valid_d, rw_idle_q, rw_idle_d;
  logic                 req_ready_q, req_ready_d;
  logic [2:0]           cmd_q, cmd_d;
  logic [3:0]           cmd_bank_q, cmd_bank_d;
  logic [17:0]          cmd_addr_q, cmd_addr_d;
  logic                 accept, last;

  always_ff @(posedge clock_t) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      mrs_word_q  <= '0;
      ref_pend_q  <= 1'b0;
      mrs_pend_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= C_NOP;
      cmd_bank_q  <= '0;
      cmd_addr_q  <= '0;
      rw_idle_q   <= 1'b1;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      mrs_word_q  <= mrs_word_d;
      ref_pend_q  <= ref_pend_d;
      mrs_pend_q  <= mrs_pend_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      cmd_bank_q  <= cmd_bank_d;
      cmd_addr_q  <= cmd_addr_d;
      rw_idle_q   <= rw_idle_d;
      req_ready_q <= req_ready_d;
    end
  end

  // Every command state lasts one cycle and loads the counter with the gap
  // to the next command; the wait states count it down to 1.
  always_comb begin
    accept     = req_valid & req_ready_q;
    last       = (cnt_q <= 8'd1);
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    if (accept) req_d = '{write: req_write, bank: req_bank, row: req_row, col: req_col};
    mrs_word_d = mrs_update_rdy ? mrs_update_cmd : mrs_word_q;
    ref_pend_d = ref_pend_q | refresh_rdy;
    mrs_pend_d = mrs_pend_q | mrs_update_rdy;

    case (state_q)
      // An offered handshake is honoured ahead of a pulse arriving in the
      // same cycle; that pulse stays pending and runs afterwards.
      S_IDLE: begin
        if (ref_pend_q)          state_d = S_PREA;
        else if (mrs_pend_q)     state_d = S_MRS;
        else if (accept)         state_d = S_ACT;
        else if (refresh_rdy)    state_d = S_PREA;
        else if (mrs_update_rdy) state_d = S_MRS;
      end
      S_ACT, S_TRCD:       state_d = last ? S_RW   : S_TRCD;
      S_RW, S_BURST:       state_d = last ? S_PRE  : S_BURST;
      S_PRE, S_TRP:        state_d = last ? S_IDLE : S_TRP;
      S_PREA, S_PREA_WAIT: state_d = last ? S_REF  : S_PREA_WAIT;
      S_REF, S_RFC:        state_d = last ? S_IDLE : S_RFC;
      S_MRS, S_MOD:        state_d = last ? S_IDLE : S_MOD;
      default:             state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && !last) cnt_d = cnt_q - 8'd1;
    case (state_d)
      S_ACT:         cnt_d = 8'(T_RCD);
      S_RW:          cnt_d = 8'(T_BURST);
      S_PRE, S_PREA: cnt_d = 8'(T_RP);
      S_REF:         cnt_d = 8'(T_RFC);
      S_MRS:         cnt_d = 8'(T_MOD);
      default:       ;
    endcase

    if (state_q == S_IDLE && state_d == S_PREA) ref_pend_d = 1'b0;
    if (state_q == S_IDLE && state_d == S_MRS)  mrs_pend_d = 1'b0;
  end

  // Outputs are decoded from the next state, so they line up with state_q.
  always_comb begin
    cmd_d      = C_NOP;
    cmd_bank_d = '0;
    cmd_addr_d = '0;
    case (state_d)
      S_ACT: begin
        cmd_d      = C_ACT;
        cmd_bank_d = req_d.bank;
        cmd_addr_d = {2'b00, req_d.row};
      end
      S_RW: begin
        cmd_d      = req_d.write ? C_WR : C_RD;
        cmd_bank_d = req_d.bank;
        cmd_addr_d = {8'h00, req_d.col};
      end
      S_PRE: begin
        cmd_d      = C_PRE;
        cmd_bank_d = req_d.bank;
      end
      S_PREA: begin
        cmd_d          = C_PREA;
        cmd_addr_d[10] = 1'b1;
      end
      S_REF: cmd_d = C_REF;
      S_MRS: begin
        cmd_d                       = C_MRS;
        cmd_addr_d[MRS_WIDTH-1:0]   = mrs_word_d;
      end
      default: ;
    endcase
    cmd_valid_d = (cmd_d != C_NOP);
    rw_idle_d   = (state_d == S_IDLE) & ~ref_pend_d & ~mrs_pend_d;
    req_ready_d = rw_idle_d & rw_proc & ~accept;
  end

  assign req_ready = req_ready_q;
  assign rw_idle   = rw_idle_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign cmd_bank  = cmd_bank_q;
  assign cmd_addr  = cmd_addr_q;

endmodule
